// File: rtl/ad9958_pkg.sv
// Shared definitions for the AD9958 register sequencers: register map,
// instruction byte layout, sequencer state encoding and frame helpers.
package ad9958_pkg;

   // AD9958 register addresses
   localparam logic [4:0] ADDR_CSR   = 5'h00;
   localparam logic [4:0] ADDR_FR1   = 5'h01;
   localparam logic [4:0] ADDR_FR2   = 5'h02;
   localparam logic [4:0] ADDR_CFR   = 5'h03;
   localparam logic [4:0] ADDR_CFTW0 = 5'h04;
   localparam logic [4:0] ADDR_CPOW0 = 5'h05;
   localparam logic [4:0] ADDR_ACR   = 5'h06;
   localparam logic [4:0] ADDR_LSRR  = 5'h07;
   localparam logic [4:0] ADDR_RDW   = 5'h08;
   localparam logic [4:0] ADDR_FDW   = 5'h09;
   localparam logic [4:0] ADDR_CW1   = 5'h0A;
   localparam logic [4:0] ADDR_CW15  = 5'h18;

   // Instruction byte: bit 7 selects read (1) or write (0), bits 4:0 address
   localparam int         INSTR_RW_BIT = 7;
   localparam logic       INSTR_WRITE  = 1'b0;

   // Sequencer states; encoding is visible on the debug state output
   typedef enum logic [2:0] {
      S_IDLE      = 3'd0,
      S_LOAD      = 3'd1,
      S_TRIG      = 3'd2,
      S_WAIT_BUSY = 3'd3,
      S_WAIT_DONE = 3'd4,
      S_GAP       = 3'd5,
      S_IOUPD     = 3'd6,
      S_FIN       = 3'd7
   } state_t;

   // Write instruction byte for a register address
   function automatic logic [7:0] write_instr(input logic [4:0] addr);
      logic [7:0] instr;
      instr               = {3'b000, addr};
      instr[INSTR_RW_BIT] = INSTR_WRITE;
      return instr;
   endfunction

   // Right-aligned SPI frame: instruction byte followed by the low len bytes
   function automatic logic [63:0] build_frame(input logic [4:0]  addr,
                                               input logic [31:0] data,
                                               input logic [2:0]  len);
      logic [7:0] instr;
      instr = write_instr(addr);
      case (len)
         3'd1:    return {48'd0, instr, data[7:0]};
         3'd2:    return {40'd0, instr, data[15:0]};
         3'd3:    return {32'd0, instr, data[23:0]};
         3'd4:    return {24'd0, instr, data[31:0]};
         default: return 64'd0;
      endcase
   endfunction

   // Nibble count for a frame of len payload bytes plus the instruction
   function automatic logic [4:0] packs_for_len(input logic [2:0] len);
      logic [4:0] bytes;
      bytes = {2'b00, len} + 5'd1;
      return bytes << 1;
   endfunction

endpackage

// File: rtl/ad9958_reg_len.sv
// Address to register-length lookup for the AD9958 register map.
// Addresses above the last channel word are reported as invalid.
module ad9958_reg_len
   import ad9958_pkg::*;
(
   input  logic [4:0] addr,
   output logic       valid,
   output logic [2:0] len
);

   // Register length in bytes by address
   always_comb begin
      valid = 1'b1;
      len   = 3'd4;
      case (addr)
         ADDR_CSR:   len = 3'd1;
         ADDR_FR1:   len = 3'd3;
         ADDR_FR2:   len = 3'd2;
         ADDR_CFR:   len = 3'd3;
         ADDR_CFTW0: len = 3'd4;
         ADDR_CPOW0: len = 3'd2;
         ADDR_ACR:   len = 3'd3;
         ADDR_LSRR:  len = 3'd2;
         default: begin
            if (addr > ADDR_CW15) begin
               valid = 1'b0;
               len   = 3'd0;
            end
         end
      endcase
   end

endmodule

// File: rtl/ad9958_write_sequencer.sv
// AD9958 register-write sequencer. Takes one command at a time, builds the
// SPI frame for four_bit_spi, triggers it, waits for completion and can
// follow up with an IO_UPDATE pulse.
//
// Handshake: a command transfers on a clock where req_valid & req_ready are
// both high; req_ready is high only while idle and req_valid is ignored
// otherwise, so the command fields need only be stable on that clock.
module ad9958_write_sequencer
   import ad9958_pkg::*;
#(
   parameter int GAP_CYCLES   = 2,
   parameter int IOUPD_CYCLES = 4,
   parameter int BUSY_TIMEOUT = 15
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [4:0]  req_addr,
   input  logic [31:0] req_data,
   input  logic        req_io_update,
   output logic        spi_trigger,
   input  logic        spi_busy,
   output logic [4:0]  spi_packs,
   output logic [63:0] spi_data,
   output logic        io_update,
   output logic        done,
   output logic        err_addr,
   output logic        err_timeout,
   output logic [2:0]  dbg_state
);

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [63:0] spi_data_q, spi_data_d;
   logic [4:0]  spi_packs_q, spi_packs_d;
   logic        upd_flag_q, upd_flag_d;
   logic        req_ready_q, req_ready_d;
   logic        spi_trigger_q, spi_trigger_d;
   logic        io_update_q, io_update_d;
   logic        done_q, done_d;
   logic        err_addr_q, err_addr_d;
   logic        err_timeout_q, err_timeout_d;

   logic        addr_valid;
   logic [2:0]  addr_len;
   logic        accept;

   ad9958_reg_len u_reg_len (
      .addr  (req_addr),
      .valid (addr_valid),
      .len   (addr_len)
   );

   assign accept = req_valid & req_ready_q;

   // Next state, frame capture, shared counter and registered-output values
   always_comb begin
      state_d       = state_q;
      spi_data_d    = spi_data_q;
      spi_packs_d   = spi_packs_q;
      upd_flag_d    = upd_flag_q;
      err_addr_d    = 1'b0;
      err_timeout_d = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (addr_valid) begin
                  state_d     = S_LOAD;
                  spi_data_d  = build_frame(req_addr, req_data, addr_len);
                  spi_packs_d = packs_for_len(addr_len);
                  upd_flag_d  = req_io_update;
               end else begin
                  err_addr_d = 1'b1;
               end
            end
         end
         // Hold off the trigger while the engine still reports busy
         S_LOAD: if (!spi_busy) state_d = S_TRIG;
         S_TRIG: state_d = S_WAIT_BUSY;
         S_WAIT_BUSY: begin
            if (spi_busy) begin
               state_d = S_WAIT_DONE;
            end else if (cnt_q == 8'(BUSY_TIMEOUT - 1)) begin
               state_d       = S_IDLE;
               err_timeout_d = 1'b1;
            end
         end
         S_WAIT_DONE: if (!spi_busy) state_d = S_GAP;
         S_GAP: begin
            if (cnt_q == 8'(GAP_CYCLES - 1)) begin
               state_d = upd_flag_q ? S_IOUPD : S_FIN;
            end
         end
         S_IOUPD: if (cnt_q == 8'(IOUPD_CYCLES - 1)) state_d = S_FIN;
         S_FIN:   state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      // One counter serves timeout, gap and pulse width; restarts on entry
      if (state_d != state_q || state_q == S_IDLE) begin
         cnt_d = 8'd0;
      end else begin
         cnt_d = cnt_q + 8'd1;
      end

      req_ready_d   = (state_d == S_IDLE);
      spi_trigger_d = (state_d == S_TRIG);
      io_update_d   = (state_d == S_IOUPD);
      done_d        = (state_d == S_FIN);
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         state_q       <= S_IDLE;
         cnt_q         <= 8'd0;
         spi_data_q    <= 64'd0;
         spi_packs_q   <= 5'd0;
         upd_flag_q    <= 1'b0;
         req_ready_q   <= 1'b0;
         spi_trigger_q <= 1'b0;
         io_update_q   <= 1'b0;
         done_q        <= 1'b0;
         err_addr_q    <= 1'b0;
         err_timeout_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         spi_data_q    <= spi_data_d;
         spi_packs_q   <= spi_packs_d;
         upd_flag_q    <= upd_flag_d;
         req_ready_q   <= req_ready_d;
         spi_trigger_q <= spi_trigger_d;
         io_update_q   <= io_update_d;
         done_q        <= done_d;
         err_addr_q    <= err_addr_d;
         err_timeout_q <= err_timeout_d;
      end
   end

   assign req_ready   = req_ready_q;
   assign spi_trigger = spi_trigger_q;
   assign spi_packs   = spi_packs_q;
   assign spi_data    = spi_data_q;
   assign io_update   = io_update_q;
   assign done        = done_q;
   assign err_addr    = err_addr_q;
   assign err_timeout = err_timeout_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_ad9958_write_sequencer.sv
// Bench for ad9958_write_sequencer: directed commands, a simple four_bit_spi
// busy model, and a scoreboard fed by the stimulus and drained by a monitor.
module tb_ad9958_write_sequencer;

   logic        clock;
   logic        reset_n;
   logic        req_valid;
   logic        req_ready;
   logic [4:0]  req_addr;
   logic [31:0] req_data;
   logic        req_io_update;
   logic        spi_trigger;
   logic        spi_busy;
   logic [4:0]  spi_packs;
   logic [63:0] spi_data;
   logic        io_update;
   logic        done;
   logic        err_addr;
   logic        err_timeout;
   logic [2:0]  dbg_state;

   int pass_cnt = 0;
   int chk_cnt  = 0;

   // frame record: {packs, data}; end record: {done,err_addr,err_timeout,io,trig,lat}
   logic [68:0] exp_frame_q[$];
   logic [16:0] exp_end_q[$];

   logic        eng_on;

   ad9958_write_sequencer #(
      .GAP_CYCLES   (2),
      .IOUPD_CYCLES (4),
      .BUSY_TIMEOUT (15)
   ) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .req_valid     (req_valid),
      .req_ready     (req_ready),
      .req_addr      (req_addr),
      .req_data      (req_data),
      .req_io_update (req_io_update),
      .spi_trigger   (spi_trigger),
      .spi_busy      (spi_busy),
      .spi_packs     (spi_packs),
      .spi_data      (spi_data),
      .io_update     (io_update),
      .done          (done),
      .err_addr      (err_addr),
      .err_timeout   (err_timeout),
      .dbg_state     (dbg_state)
   );

   // clock / reset block
   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
   endtask

   function automatic logic [16:0] end_rec(input logic [2:0] flags, input logic [3:0] io,
                                           input logic [1:0] trig, input logic [7:0] lat);
      return {flags, io, trig, lat};
   endfunction

   // engine model: busy rises 2 clocks after a trigger and lasts 12 clocks
   initial begin
      spi_busy = 1'b0;
      forever begin
         @(negedge clock);
         if (spi_trigger && eng_on && reset_n) begin
            repeat (2) @(posedge clock);
            #1 spi_busy = 1'b1;
            repeat (12) @(posedge clock);
            #1 spi_busy = 1'b0;
         end
      end
   end

   // monitor: per-command latency, trigger and io_update counts, scoreboard pops
   logic        mon_active = 1'b0;
   logic [7:0]  mon_lat    = 8'd0;
   logic [3:0]  mon_io     = 4'd0;
   logic [1:0]  mon_trig   = 2'd0;
   logic [68:0] mon_frame;
   logic [16:0] mon_end;

   always @(negedge clock) begin
      if (!reset_n) begin
         mon_active = 1'b0;
         mon_io     = 4'd0;
         mon_trig   = 2'd0;
      end else begin
         if (mon_active) mon_lat = mon_lat + 8'd1;
         if (spi_trigger) begin
            mon_trig = mon_trig + 2'd1;
            check("trig_no_busy", 128'(spi_busy), 128'(1'b0));
            if (exp_frame_q.size() == 0) begin
               check("frame_unexpected", 128'(1'b1), 128'(1'b0));
            end else begin
               mon_frame = exp_frame_q.pop_front();
               check("frame", 128'({spi_packs, spi_data}), 128'(mon_frame));
            end
         end
         if (io_update) mon_io = mon_io + 4'd1;
         if (done || err_addr || err_timeout) begin
            if (done) check("fin_ready_low", 128'(req_ready), 128'(1'b0));
            if (exp_end_q.size() == 0) begin
               check("end_unexpected", 128'(1'b1), 128'(1'b0));
            end else begin
               mon_end = exp_end_q.pop_front();
               check("end", 128'({done, err_addr, err_timeout, mon_io, mon_trig, mon_lat}),
                     128'(mon_end));
            end
            mon_active = 1'b0;
         end
         if (req_valid && req_ready) begin
            check("accept_when_free", 128'(mon_active), 128'(1'b0));
            mon_active = 1'b1;
            mon_lat    = 8'd0;
            mon_io     = 4'd0;
            mon_trig   = 2'd0;
         end
      end
   end

   // driver: present a command and return on the clock after it is accepted
   task automatic send(input logic [4:0] a, input logic [31:0] d, input logic u);
      logic got;
      got           = 1'b0;
      req_addr      = a;
      req_data      = d;
      req_io_update = u;
      req_valid     = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clock);
         if (req_ready) begin
            got = 1'b1;
            break;
         end
      end
      if (!got) check("accept_timeout", 128'(1'b0), 128'(1'b1));
      @(posedge clock);
      #1;
   endtask

   task automatic drain();
      logic empty;
      empty = 1'b0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clock);
         if (exp_end_q.size() == 0 && exp_frame_q.size() == 0) begin
            empty = 1'b1;
            break;
         end
      end
      if (!empty) check("drain_timeout", 128'(1'b0), 128'(1'b1));
      repeat (3) @(negedge clock);
      @(posedge clock);
      #1;
   endtask

   initial begin
      logic seen;
      reset_n       = 1'b0;
      req_valid     = 1'b0;
      req_addr      = 5'd0;
      req_data      = 32'd0;
      req_io_update = 1'b0;
      eng_on        = 1'b1;

      // reset state
      repeat (4) @(posedge clock);
      @(negedge clock);
      check("reset_outputs",
            128'({req_ready, spi_trigger, spi_packs, spi_data, io_update, done, err_addr, err_timeout}),
            128'd0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      check("ready_at_release", 128'(req_ready), 128'(1'b0));
      @(negedge clock);
      check("ready_after_release", 128'(req_ready), 128'(1'b1));
      @(posedge clock);
      #1;

      // CFTW0, no update: frame 0x0412345678, 10 nibbles
      exp_frame_q.push_back({5'd10, 64'h00_0000_0412345678});
      exp_end_q.push_back(end_rec(3'b100, 4'd0, 2'd1, 8'd19));
      send(5'h04, 32'h12345678, 1'b0);
      req_valid = 1'b0;
      drain();

      // CSR with update: frame 0x00F0, 4 nibbles, 4-clock io_update
      exp_frame_q.push_back({5'd4, 64'h00F0});
      exp_end_q.push_back(end_rec(3'b100, 4'd4, 2'd1, 8'd23));
      send(5'h00, 32'hFFFFFFF0, 1'b1);
      req_valid = 1'b0;
      drain();

      // invalid address: single err_addr, no trigger, ready again next clock
      exp_end_q.push_back(end_rec(3'b010, 4'd0, 2'd0, 8'd1));
      send(5'h1F, 32'hDEADBEEF, 1'b1);
      req_valid = 1'b0;
      @(negedge clock);
      check("ready_after_err_addr", 128'(req_ready), 128'(1'b1));
      drain();

      // busy never rises: err_timeout 15 clocks into WAIT_BUSY
      eng_on = 1'b0;
      exp_frame_q.push_back({5'd10, 64'h0A_CAFEF00D});
      exp_end_q.push_back(end_rec(3'b001, 4'd0, 2'd1, 8'd18));
      send(5'h0A, 32'hCAFEF00D, 1'b1);
      req_valid = 1'b0;
      drain();
      check("idle_after_timeout", 128'({req_ready, dbg_state}), 128'({1'b1, 3'd0}));
      eng_on = 1'b1;

      // back-to-back with req_valid held: FR1 then CPOW0
      exp_frame_q.push_back({5'd8, 64'h01D00000});
      exp_end_q.push_back(end_rec(3'b100, 4'd0, 2'd1, 8'd19));
      exp_frame_q.push_back({5'd6, 64'h053FFF});
      exp_end_q.push_back(end_rec(3'b100, 4'd0, 2'd1, 8'd19));
      send(5'h01, 32'h00D00000, 1'b0);
      send(5'h05, 32'h00003FFF, 1'b0);
      req_valid = 1'b0;
      drain();

      // reset on the second io_update clock
      exp_frame_q.push_back({5'd6, 64'h02ABCD});
      send(5'h02, 32'h0000ABCD, 1'b1);
      req_valid = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         if (io_update) begin
            seen = 1'b1;
            break;
         end
      end
      check("io_update_seen", 128'(seen), 128'(1'b1));
      @(posedge clock);
      #1 reset_n = 1'b0;
      @(negedge clock);
      @(negedge clock);
      check("reset_mid_ioupd",
            128'({io_update, req_ready, done, spi_data}), 128'd0);
      @(posedge clock);
      #1 reset_n = 1'b1;
      @(negedge clock);
      check("ready_low_first", 128'(req_ready), 128'(1'b0));
      @(negedge clock);
      check("ready_after_reset", 128'(req_ready), 128'(1'b1));
      repeat (20) @(negedge clock);

      check("scoreboard_empty", 128'({exp_frame_q.size() == 0, exp_end_q.size() == 0}),
            128'(2'b11));
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end

endmodule

// File: doc/ad9958_write_sequencer.md
Name: ad9958_write_sequencer

Overview:
Register-write sequencer for the AD9958 DDS that drives four_bit_spi. It accepts one register-write command at a time over a valid/ready interface. For each command it builds the instruction byte and payload, looks up the register length, and triggers the 4-bit SPI engine, then waits for the engine to finish. It can optionally pulse IO_UPDATE afterwards. It sits between the host/command logic and four_bit_spi and is the only driver of the engine's trigger, packs_to_send and data_input.

Parameters:
GAP_CYCLES, 2, idle clocks after spi_busy falls before IO_UPDATE or done (1..15)
IOUPD_CYCLES, 4, width of the io_update high pulse in clocks (1..15)
BUSY_TIMEOUT, 15, clocks allowed in WAIT_BUSY for spi_busy to rise before aborting (1..255)

Ports:
clock  in  1  system clock; same clock as four_bit_spi
reset_n  in  1  synchronous, active-low reset
req_valid  in  1  command valid
req_ready  out  1  high only in IDLE; a command is accepted when req_valid & req_ready
req_addr  in  5  AD9958 register address
req_data  in  32  register value, right-aligned; only the low 8*L bits are used
req_io_update  in  1  pulse io_update after this write
spi_trigger  out  1  to four_bit_spi trigger
spi_busy  in  1  from four_bit_spi busy
spi_packs  out  5  to four_bit_spi packs_to_send (nibble count)
spi_data  out  64  to four_bit_spi data_input
io_update  out  1  AD9958 IO_UPDATE pin
done  out  1  one-clock pulse when a command completes normally
err_addr  out  1  one-clock pulse when a command with an invalid address is rejected
err_timeout  out  1  one-clock pulse when spi_busy fails to assert in time

Behaviour:
- Reset values: req_ready=0, spi_trigger=0, spi_packs=0, spi_data=0, io_update=0, done=0, err_addr=0, err_timeout=0; state=IDLE. req_ready rises on the first clock after reset is released.
- Length L (bytes) by address: 0x00 → 1; 0x01 → 3; 0x02 → 2; 0x03 → 3; 0x04 → 4; 0x05 → 2; 0x06 → 3; 0x07 → 2; 0x08..0x18 → 4; 0x19..0x1F → invalid.
- Frame format: spi_data = {zeros, instr[7:0], req_data[8L-1:0]}, where instr = {1'b0 (write), 2'b00, req_addr}. spi_packs = 2*(L+1), giving 4, 6, 8 or 10. Bits above 8L+7 are zero.
- spi_data, spi_packs and the io_update flag are registered on accept and held stable until the sequencer returns to IDLE.
- States:
  - IDLE: req_ready=1. On accept with a valid address → LOAD. On accept with an invalid address → err_addr pulses the next clock, the state stays IDLE, and there is no trigger.
  - LOAD: 1 clock, outputs settle → TRIG.
  - TRIG: spi_trigger=1 for exactly 1 clock → WAIT_BUSY.
  - WAIT_BUSY: a counter runs from 0. spi_busy=1 → WAIT_DONE. If the counter reaches BUSY_TIMEOUT first → err_timeout pulse, then IDLE. No done and no io_update on timeout.
  - WAIT_DONE: waits for spi_busy=0 → GAP. There is no timeout in this state.
  - GAP: GAP_CYCLES clocks. Then → IOUPD if the flag is set, else → FIN.
  - IOUPD: io_update=1 for exactly IOUPD_CYCLES clocks → FIN.
  - FIN: done=1 for 1 clock → IDLE. req_ready is 0 in FIN, so back-to-back commands are separated by at least one IDLE clock.
- req_valid outside IDLE is ignored; the command is not latched.
- spi_trigger is never asserted while spi_busy=1.
- Reset mid-operation (any state) → all outputs return to reset values on the next clock. Any io_update pulse in progress is cut short.
- The counters (timeout and gap/pulse) are shared and cleared on every state entry. The counter is 8 bits wide.

Decomposition:
- Shared package ad9958_pkg: register address constants (CSR, FR1, FR2, CFR, CFTW0, CPOW0, ACR, LSRR, RDW, FDW, CW1..CW15), instruction R/W bit position, state encoding constants.
- Sub-module ad9958_reg_len: combinational address → {valid, L[2:0]} lookup, reused later by a read sequencer.

Test Plan:
- CFTW0 write: addr=0x04, data=0x12345678, io_update flag=0; engine model asserts busy 2 clocks after trigger for 12 clocks. Required: spi_data=0x0412345678, spi_packs=10, a single 1-clock trigger, done after GAP, io_update stays 0.
- CSR write with update: addr=0x00, data=0xFFFFFFF0, flag=1. Required: spi_data=0x00F0, spi_packs=4, io_update high for exactly 4 clocks after GAP, then done.
- Invalid address: addr=0x1F. Required: err_addr single pulse, spi_trigger never asserted, req_ready=1 on the following clock.
- Busy timeout: engine model never asserts busy. Required: err_timeout exactly 15 clocks after entering WAIT_BUSY, no done, no io_update, back in IDLE.
- Back-to-back: FR1 (0x01, 0x00D00000) then CPOW0 (0x05, 0x3FFF) with req_valid held high. Required: spi_packs 8 then 6, second accept only after the first done, with at least 1 IDLE clock between them.
- Reset mid-IOUPD: assert reset_n=0 on the 2nd io_update clock. Required: io_update=0 and req_ready=0 on the next clock, no done pulse, req_ready=1 on the first clock after reset is released.
